// File: rtl/keccak_chi_compress_if.sv
// Row-in / frame-out bundle for keccak_chi_compress: 45 chi component outputs in,
// ROWS packed 3-share chi rows out, both sides valid/ready.
interface keccak_chi_compress_if #(
  parameter int ROWS = 5
);
  logic                cf_valid;
  logic [44:0]         cf;
  logic                cf_ready;
  logic                out_valid;
  logic                out_ready;
  logic [5*ROWS-1:0]   out_s1;
  logic [5*ROWS-1:0]   out_s2;
  logic [5*ROWS-1:0]   out_s3;

  modport master (
    output cf_valid, cf, out_ready,
    input  cf_ready, out_valid, out_s1, out_s2, out_s3
  );

  modport slave (
    input  cf_valid, cf, out_ready,
    output cf_ready, out_valid, out_s1, out_s2, out_s3
  );
endinterface

// File: rtl/keccak_chi_compress.sv
// Registers 45 masked chi component outputs (glitch barrier), XOR-compresses them to 3 shares
// of a 5-bit row and packs ROWS rows per frame; row written 1 edge after accept, one row held while FULL stalls.
module keccak_chi_compress #(
  parameter int ROWS = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  keccak_chi_compress_if.slave   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = 5 * ROWS;

  typedef enum logic {FILL, FULL} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [44:0]     cf_q, cf_d;
  logic            cf_v_q, cf_v_d;
  logic [FW-1:0]   acc_s1_q, acc_s1_d;
  logic [FW-1:0]   acc_s2_q, acc_s2_d;
  logic [FW-1:0]   acc_s3_q, acc_s3_d;

  logic [4:0]      y1, y2, y3;
  logic            acc_take;
  logic            cf_ready;
  logic            cf_accept;

  // Compression reads only the registered components so no XOR sees raw cf glitches.
  always_comb begin
    y1 = '0;
    y2 = '0;
    y3 = '0;
    for (int j = 0; j < 5; j++) begin
      y1[j] = ^cf_q[9*j   +: 3];
      y2[j] = ^cf_q[9*j+3 +: 3];
      y3[j] = ^cf_q[9*j+6 +: 3];
    end
  end

  always_comb begin
    acc_take  = cf_v_q && ((state_q == FILL) || bus.out_ready);
    cf_ready  = !cf_v_q || acc_take;
    cf_accept = bus.cf_valid && cf_ready;

    cf_d     = cf_q;
    cf_v_d   = cf_v_q;
    acc_s1_d = acc_s1_q;
    acc_s2_d = acc_s2_q;
    acc_s3_d = acc_s3_q;
    row_d    = row_q;
    state_d  = state_q;

    if (cf_accept) begin
      cf_d   = bus.cf;
      cf_v_d = 1'b1;
    end else if (acc_take) begin
      cf_v_d = 1'b0;
    end

    if (acc_take) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == RW'(r)) begin
          acc_s1_d[5*r +: 5] = y1;
          acc_s2_d[5*r +: 5] = y2;
          acc_s3_d[5*r +: 5] = y3;
        end
      end
      // Taking the last row while FULL also completes the previous frame's handshake.
      if (row_q == RW'(ROWS - 1)) begin
        row_d   = '0;
        state_d = FULL;
      end else begin
        row_d   = row_q + RW'(1);
        state_d = FILL;
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      row_q    <= '0;
      cf_q     <= '0;
      cf_v_q   <= 1'b0;
      acc_s1_q <= '0;
      acc_s2_q <= '0;
      acc_s3_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cf_q     <= cf_d;
      cf_v_q   <= cf_v_d;
      acc_s1_q <= acc_s1_d;
      acc_s2_q <= acc_s2_d;
      acc_s3_q <= acc_s3_d;
    end
  end

  assign bus.cf_ready  = cf_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_s1    = acc_s1_q;
  assign bus.out_s2    = acc_s2_q;
  assign bus.out_s3    = acc_s3_q;
endmodule

// File: tb/tb_keccak_chi_compress.sv
// Bench for keccak_chi_compress: directed cases plus random traffic scored against a
// queue model of accepted rows (frame = next ROWS rows, valid two edges after the last one).
module tb_keccak_chi_compress;
  localparam int ROWS = 5;
  localparam int FW   = 5 * ROWS;

  typedef struct {
    logic [44:0] cf;
    int          t;
  } row_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   cyc;
  row_t q[$];

  keccak_chi_compress_if #(.ROWS(ROWS)) bus ();

  keccak_chi_compress #(.ROWS(ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] rnd45();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[44:0];
  endfunction

  // Share s (0-based) of group j is the parity of the three components 9j+3s..9j+3s+2.
  function automatic logic share_bit(input logic [44:0] c, input int s, input int j);
    return c[9*j + 3*s] ^ c[9*j + 3*s + 1] ^ c[9*j + 3*s + 2];
  endfunction

  function automatic logic [FW-1:0] exp_share(input int s);
    logic [FW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < 5; j++)
        v[5*r + j] = share_bit(q[r].cf, s, j);
    return v;
  endfunction

  // Called at the falling edge with inputs already set; scores this cycle, then advances one edge.
  task automatic tick();
    logic exp_v, exp_rdy, hs, acc;
    #1;
    if (rst_n) begin
      exp_v   = (q.size() >= ROWS) && (q[ROWS-1].t + 2 <= cyc);
      exp_rdy = !(exp_v && !bus.out_ready && (q.size() > ROWS));
      check("out_valid", 64'(bus.out_valid), 64'(exp_v));
      check("cf_ready", 64'(bus.cf_ready), 64'(exp_rdy));
      if (exp_v && bus.out_valid) begin
        check("frame_s1", 64'(bus.out_s1), 64'(exp_share(0)));
        check("frame_s2", 64'(bus.out_s2), 64'(exp_share(1)));
        check("frame_s3", 64'(bus.out_s3), 64'(exp_share(2)));
      end
      hs  = bus.out_valid && bus.out_ready;
      acc = bus.cf_valid && bus.cf_ready;
      if (hs && (q.size() >= ROWS))
        repeat (ROWS) void'(q.pop_front());
      if (acc)
        q.push_back('{bus.cf, cyc});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n_acc;
    int n_pulse;
    int first_pulse;
    int last_pulse;

    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.cf_valid  = 1'b0;
    bus.cf        = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state held with no input.
    for (int i = 0; i < 10; i++) begin
      #1;
      check("rst_cf_ready", 64'(bus.cf_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_s", 64'({bus.out_s1, bus.out_s2}) | 64'(bus.out_s3), 64'd0);
      tick();
    end

    // Component-to-bit mapping.
    bus.out_ready = 1'b1;
    bus.cf_valid  = 1'b1;
    bus.cf = 45'h1;            tick();
    bus.cf = 45'h200;          tick();
    bus.cf = 45'h8;            tick();
    bus.cf = 45'h0;            tick();
    bus.cf = 45'h100000000000; tick();
    bus.cf_valid = 1'b0;
    check("map_not_yet", 64'(bus.out_valid), 64'd0);
    tick();
    check("map_valid", 64'(bus.out_valid), 64'd1);
    check("map_s1", 64'(bus.out_s1), 64'h000041);
    check("map_s2", 64'(bus.out_s2), 64'h000400);
    check("map_s3", 64'(bus.out_s3), 64'h1000000);
    tick();

    // All-ones rows; out_valid rises after the 6th edge from the first accept.
    bus.cf_valid = 1'b1;
    bus.cf       = 45'h1FFF_FFFF_FFFF;
    repeat (5) tick();
    bus.cf_valid = 1'b0;
    check("ones_edge5", 64'(bus.out_valid), 64'd0);
    tick();
    check("ones_edge6", 64'(bus.out_valid), 64'd1);
    check("ones_s1", 64'(bus.out_s1), 64'h1FFFFFF);
    check("ones_s2", 64'(bus.out_s2), 64'h1FFFFFF);
    check("ones_s3", 64'(bus.out_s3), 64'h1FFFFFF);
    tick();

    // Backpressure: 5 rows fill the frame, a 6th is held, then cf_ready drops.
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.cf_valid = 1'b1;
      bus.cf       = rnd45();
      #1;
      check("bp_cf_ready", 64'(bus.cf_ready), (i < 6) ? 64'd1 : 64'd0);
      if (bus.cf_ready) n_acc++;
      tick();
    end
    check("bp_accepts", 64'(n_acc), 64'd6);
    check("bp_held_valid", 64'(bus.out_valid), 64'd1);
    bus.cf_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_after_hs_valid", 64'(bus.out_valid), 64'd0);
    check("bp_after_hs_rdy", 64'(bus.cf_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.cf_valid = 1'b1;
      bus.cf       = rnd45();
      tick();
    end
    bus.cf_valid = 1'b0;
    repeat (3) tick();
    check("bp_drained", 64'(q.size()), 64'd0);

    // Back-to-back: two frames, single-cycle pulses 5 cycles apart.
    n_pulse = 0;
    first_pulse = -1;
    last_pulse  = -1;
    for (int i = 0; i < 14; i++) begin
      bus.cf_valid = (i < 10);
      bus.cf       = rnd45();
      tick();
      if (bus.out_valid) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
      end
    end
    bus.cf_valid = 1'b0;
    check("b2b_pulses", 64'(n_pulse), 64'd2);
    check("b2b_gap", 64'(last_pulse - first_pulse), 64'd5);
    check("b2b_drained", 64'(q.size()), 64'd0);

    // Reset mid-frame discards the partial frame and the held row.
    bus.cf_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cf = rnd45();
      tick();
    end
    bus.cf_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.cf_valid = 1'b1;
    bus.cf       = 45'h1;
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_wait", 64'(bus.out_valid), 64'd0);
      tick();
    end
    bus.cf_valid = 1'b0;
    tick();
    check("mid_rst_frame_v", 64'(bus.out_valid), 64'd1);
    check("mid_rst_s1", 64'(bus.out_s1), 64'h0108421);
    check("mid_rst_s2", 64'(bus.out_s2), 64'h0);
    check("mid_rst_s3", 64'(bus.out_s3), 64'h0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.cf_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.cf        = rnd45();
      tick();
    end
    bus.cf_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("rand_no_stuck_frame", 64'(q.size() < ROWS), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
